// File: rtl/aes_pkg.sv
// Shared AES helpers for the round datapath.
//   shift_offset : ShiftRows row offset s_r for a given column count and row
//   permute      : forward/inverse ShiftRows on a state of up to 256 bits. The
//                  state occupies the low 32*nb bits, column-major, and byte
//                  (r,c) sits at the most-significant end for c=0, r=0.
//   mode_e       : per-beat permutation direction
package aes_pkg;

  localparam int unsigned MaxNb = 8;
  localparam int unsigned MaxW  = 32 * MaxNb;

  typedef enum logic {
    ModeFwd = 1'b0,
    ModeInv = 1'b1
  } mode_e;

  // Rijndael uses 0,1,2,3 for 4 and 6 columns and 0,1,3,4 for 8 columns.
  function automatic int unsigned shift_offset(input int unsigned nb, input int unsigned r);
    if (nb == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  function automatic logic [MaxW-1:0] permute(input logic [MaxW-1:0] data,
                                               input mode_e mode,
                                               input int unsigned nb);
    logic [MaxW-1:0] res;
    int unsigned     w;
    int unsigned     s;
    int unsigned     src;
    logic [7:0]      dst_lsb;
    logic [7:0]      src_lsb;
    res = '0;
    w   = 32 * nb;
    for (int unsigned c = 0; c < MaxNb; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        if (c < nb) begin
          s   = shift_offset(nb, r);
          src = (mode == ModeFwd) ? (c + s) % nb : (c + nb - s) % nb;
          // Byte k = 4c+r has its lsb at w - 8*(k+1).
          dst_lsb = 8'(w - 8 * (4 * c + r + 1));
          src_lsb = 8'(w - 8 * (4 * src + r + 1));
          res[dst_lsb +: 8] = data[src_lsb +: 8];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/shift_rows_stream_if.sv
// Valid/ready stream bundle for shift_rows_stream.
//   in_*  : upstream beat (data, sideband tag, per-beat inverse flag)
//   out_* : downstream beat after permutation
// master = producer/consumer side (the environment), slave = the unit.
interface shift_rows_stream_if #(
  parameter int unsigned W     = 128,
  parameter int unsigned TAG_W = 4
) ();

  logic             in_valid;
  logic             in_ready;
  logic             in_inv;
  logic [W-1:0]     in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_inv, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_inv, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/pipe_skid.sv
// Generic two-entry valid/ready skid buffer.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   flush_i            : synchronous drop of every held beat
//   in_valid_i/ready_o : upstream handshake, in_data_i payload
//   out_valid_o/ready_i: downstream handshake, out_data_o payload (MAIN entry)
// Both handshake outputs decode straight from the state register, so in_ready_o
// has no combinational path from out_ready_i.
module pipe_skid #(
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o
);

  // Bit 0 = MAIN full, bit 1 = SKID full.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StFull  = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          accept;
  logic          drain;

  assign out_valid_o = state_q[0];
  assign in_ready_o  = ~state_q[1];
  assign out_data_o  = main_q;

  assign accept = in_valid_i & in_ready_o;
  assign drain  = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          main_d  = in_data_i;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && drain) begin
          main_d = in_data_i;
        end else if (accept) begin
          skid_d  = in_data_i;
          state_d = StFull;
        end else if (drain) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (drain) begin
          main_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    // A flushed cycle must not capture the beat offered alongside it.
    if (flush_i) begin
      state_d = StEmpty;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/shift_rows_stream.sv
// Streaming AES ShiftRows / InvShiftRows for 4, 6 or 8 columns.
//   NB    : columns in the state (4, 6 or 8), data width W = 32*NB
//   TAG_W : sideband tag width (>= 1)
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear of all held beats
//   bus        : valid/ready stream (in_data/in_tag/in_inv in, out_data/out_tag out)
// The permutation is applied combinationally before the skid buffer, so only
// permuted data and tag are stored and each beat carries its own mode.
module shift_rows_stream
  import aes_pkg::*;
#(
  parameter int unsigned NB    = 4,
  parameter int unsigned TAG_W = 4
) (
  input logic                clk,
  input logic                rst_n,
  input logic                flush,
  shift_rows_stream_if.slave bus
);

  localparam int unsigned W  = 32 * NB;
  localparam int unsigned DW = W + TAG_W;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $fatal(1, "shift_rows_stream: NB must be 4, 6 or 8");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $fatal(1, "shift_rows_stream: TAG_W must be at least 1");
  end

  logic [MaxW-1:0] din_ext;
  logic [MaxW-1:0] perm_full;
  logic            unused_perm;
  logic [DW-1:0]   skid_in;
  logic [DW-1:0]   skid_out;

  always_comb begin
    din_ext        = '0;
    din_ext[W-1:0] = bus.in_data;
  end

  assign perm_full   = permute(din_ext, mode_e'(bus.in_inv), NB);
  // Bits above W are always zero; fold them so nothing is left dangling.
  assign unused_perm = ^perm_full;

  // Zero the payload when no beat is offered so MAIN never sees X.
  assign skid_in = bus.in_valid ? {perm_full[W-1:0], bus.in_tag} : '0;

  pipe_skid #(
    .DW (DW)
  ) u_skid (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .in_data_i   (skid_in),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (skid_out)
  );

  assign bus.out_data = skid_out[DW-1:TAG_W];
  assign bus.out_tag  = skid_out[TAG_W-1:0];

endmodule

// File: tb/tb_shift_rows_stream.sv
// Directed bench for shift_rows_stream: NB=4 and NB=8 instances on one clock.
module tb_shift_rows_stream;

  localparam logic [127:0] In4    = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
  localparam logic [127:0] Fwd4   = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] Inv4   = 128'hd4415df1_e02752e5_b8bf1130_1eb498ae;
  localparam logic [255:0] In8    =
    256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
  localparam logic [255:0] Fwd8   =
    256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f;

  logic clk;
  logic rst_n;
  logic flush;
  int   n_vec;
  int   n_err;

  shift_rows_stream_if #(.W(128), .TAG_W(4)) if4 ();
  shift_rows_stream_if #(.W(256), .TAG_W(4)) if8 ();

  shift_rows_stream #(.NB(4), .TAG_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (if4)
  );

  shift_rows_stream #(.NB(8), .TAG_W(4)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (if8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic v, input logic inv, input logic [127:0] d,
                        input logic [3:0] t);
    if4.in_valid = v;
    if4.in_inv   = inv;
    if4.in_data  = d;
    if4.in_tag   = t;
  endtask

  task automatic expect4(input string tag, input logic v, input logic [127:0] d,
                         input logic [3:0] t);
    check({tag, ".valid"}, 256'(if4.out_valid), 256'(v));
    if (v) begin
      check({tag, ".data"}, 256'(if4.out_data), 256'(d));
      check({tag, ".tag"}, 256'(if4.out_tag), 256'(t));
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    flush = 1'b0;
    rst_n = 1'b1;
    drive4(1'b0, 1'b0, '0, '0);
    if4.out_ready = 1'b1;
    if8.in_valid  = 1'b0;
    if8.in_inv    = 1'b0;
    if8.in_data   = '0;
    if8.in_tag    = '0;
    if8.out_ready = 1'b1;

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    check("rst.out_valid", 256'(if4.out_valid), 256'(0));
    check("rst.in_ready", 256'(if4.in_ready), 256'(1));
    check("rst.out_data", 256'(if4.out_data), 256'(0));
    check("rst.out_tag", 256'(if4.out_tag), 256'(0));
    check("rst.out_valid8", 256'(if8.out_valid), 256'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // NB=4: FIPS-197 round 1 vector, then alternating modes at full rate
    drive4(1'b1, 1'b0, In4, 4'd1);
    cyc();
    expect4("fwd4", 1'b1, Fwd4, 4'd1);
    drive4(1'b1, 1'b1, Fwd4, 4'd2);
    cyc();
    expect4("inv4", 1'b1, In4, 4'd2);
    check("inv4.in_ready", 256'(if4.in_ready), 256'(1));
    drive4(1'b1, 1'b1, In4, 4'd3);
    cyc();
    expect4("inv4b", 1'b1, Inv4, 4'd3);
    drive4(1'b1, 1'b0, In4, 4'd4);
    cyc();
    expect4("fwd4b", 1'b1, Fwd4, 4'd4);
    drive4(1'b0, 1'b0, '0, '0);
    cyc();
    expect4("idle4", 1'b0, '0, '0);

    // NB=8 forward and inverse
    if8.in_valid = 1'b1;
    if8.in_inv   = 1'b0;
    if8.in_data  = In8;
    if8.in_tag   = 4'd5;
    cyc();
    check("fwd8.valid", 256'(if8.out_valid), 256'(1));
    check("fwd8.data", if8.out_data, Fwd8);
    check("fwd8.tag", 256'(if8.out_tag), 256'(5));
    if8.in_inv  = 1'b1;
    if8.in_data = Fwd8;
    if8.in_tag  = 4'd6;
    cyc();
    check("inv8.data", if8.out_data, In8);
    check("inv8.tag", 256'(if8.out_tag), 256'(6));
    if8.in_valid = 1'b0;
    cyc();
    check("idle8.valid", 256'(if8.out_valid), 256'(0));

    // Backpressure: two beats fill MAIN+SKID, third waits
    if4.out_ready = 1'b0;
    drive4(1'b1, 1'b0, {16{8'h11}}, 4'd1);
    cyc();
    expect4("bp1", 1'b1, {16{8'h11}}, 4'd1);
    check("bp1.in_ready", 256'(if4.in_ready), 256'(1));
    drive4(1'b1, 1'b0, {16{8'h22}}, 4'd2);
    cyc();
    expect4("bp2", 1'b1, {16{8'h11}}, 4'd1);
    check("bp2.in_ready", 256'(if4.in_ready), 256'(0));
    drive4(1'b1, 1'b0, {16{8'h33}}, 4'd3);
    cyc();
    expect4("bp3", 1'b1, {16{8'h11}}, 4'd1);
    check("bp3.in_ready", 256'(if4.in_ready), 256'(0));
    if4.out_ready = 1'b1;
    cyc();
    expect4("bp_rel2", 1'b1, {16{8'h22}}, 4'd2);
    check("bp_rel2.in_ready", 256'(if4.in_ready), 256'(1));
    cyc();
    expect4("bp_rel3", 1'b1, {16{8'h33}}, 4'd3);
    drive4(1'b0, 1'b0, '0, '0);
    cyc();
    expect4("bp_done", 1'b0, '0, '0);

    // Flush while FULL with a beat offered
    if4.out_ready = 1'b0;
    drive4(1'b1, 1'b0, {16{8'h44}}, 4'd4);
    cyc();
    drive4(1'b1, 1'b0, {16{8'h55}}, 4'd5);
    cyc();
    check("fl_full.in_ready", 256'(if4.in_ready), 256'(0));
    drive4(1'b1, 1'b0, {16{8'h66}}, 4'd6);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drive4(1'b0, 1'b0, '0, '0);
    expect4("fl_full", 1'b0, '0, '0);
    check("fl_full.in_ready2", 256'(if4.in_ready), 256'(1));
    // Flush in ONE with an accepted-looking beat: that beat must be dropped too
    drive4(1'b1, 1'b0, {16{8'h77}}, 4'd7);
    cyc();
    drive4(1'b1, 1'b0, {16{8'h88}}, 4'd8);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    expect4("fl_one", 1'b0, '0, '0);
    if4.out_ready = 1'b1;
    drive4(1'b1, 1'b0, {16{8'h99}}, 4'd9);
    cyc();
    expect4("post_fl", 1'b1, {16{8'h99}}, 4'd9);
    drive4(1'b0, 1'b0, '0, '0);
    cyc();
    expect4("post_fl_idle", 1'b0, '0, '0);

    // Asynchronous reset mid-stream
    drive4(1'b1, 1'b0, In4, 4'd10);
    cyc();
    expect4("pre_rst", 1'b1, Fwd4, 4'd10);
    if4.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst.out_valid", 256'(if4.out_valid), 256'(0));
    check("arst.out_data", 256'(if4.out_data), 256'(0));
    check("arst.out_tag", 256'(if4.out_tag), 256'(0));
    check("arst.in_ready", 256'(if4.in_ready), 256'(1));
    if4.out_ready = 1'b1;
    drive4(1'b1, 1'b1, In4, 4'd11);
    #4 rst_n = 1'b1;
    cyc();
    expect4("resume", 1'b1, Inv4, 4'd11);
    drive4(1'b0, 1'b0, '0, '0);
    cyc();
    expect4("resume_idle", 1'b0, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_rows_stream.md
# shift_rows_stream

Parametrised, streaming AES/Rijndael ShiftRows unit supporting forward and inverse permutation for block widths of 128, 192 or 256 bits. It sits between SubBytes and MixColumns in the round datapath. It carries a per-beat mode bit and a sideband tag. It provides a registered valid/ready interface with full throughput under backpressure, via an internal skid buffer.

## Interface
- NB, 4 — columns in the state; legal values 4, 6, 8; data width W = 32*NB
- TAG_W, 4 — width of the sideband tag carried alongside each beat (minimum 1)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- flush  in  1  synchronous clear of all held beats
- in_valid  in  1  input beat present
- in_ready  out  1  block can accept a beat this cycle
- in_inv  in  1  0 = forward ShiftRows, 1 = InvShiftRows
- in_data  in  W  state, column-major
- in_tag  in  TAG_W  sideband, passed through unchanged
- out_valid  out  1  output beat present
- out_ready  in  1  downstream accepts
- out_data  out  W  permuted state
- out_tag  out  TAG_W  tag of the output beat

## Operation
- Byte (r,c) with r in 0..3 and c in 0..NB-1 occupies bits [W-1-8*(4c+r) -: 8].
- Row offsets s_r:
  - NB=4 or 6: 0,1,2,3
  - NB=8: 0,1,3,4
- Forward: out(r,c) = in(r,(c+s_r) mod NB).
- Inverse: out(r,c) = in(r,(c−s_r+NB) mod NB).
- The permutation is applied combinationally at the input. The mode is captured per beat, so consecutive beats may mix modes freely.
- Storage is two entries: main output register (MAIN) and skid register (SKID). Only the permuted data and tag are stored; the mode is not stored.
- States:
  - EMPTY: out_valid=0, in_ready=1
  - ONE: MAIN full, SKID empty, in_ready=1
  - FULL: MAIN and SKID full, in_ready=0
- Transitions, with accept = in_valid & in_ready and drain = out_valid & out_ready:
  - EMPTY→ONE on accept.
  - ONE: accept & !drain → FULL; !accept & drain → EMPTY; accept & drain → ONE, with MAIN loaded with the new beat.
  - FULL: drain → ONE, with SKID moving to MAIN.
- Beats leave in acceptance order; no beat is lost or duplicated.
- flush=1: next state is EMPTY regardless of other inputs. A beat offered in the same cycle is dropped. out_valid=0 and in_ready=1 from the following cycle.
- NB outside {4,6,8} is a fatal elaboration error.

## Timing
- Reset values: out_valid=0, in_ready=1, out_data=0, out_tag=0, SKID contents=0.
- Latency: a beat accepted in cycle n appears with out_valid=1 in cycle n+1 when the block was EMPTY or draining.
- Throughput: 1 beat/cycle while out_ready=1.
- in_ready is a register output; it has no combinational path from out_ready.
- out_data and out_tag are held stable while out_valid=1 and out_ready=0.
- Reset asserted mid-stream: all held beats are discarded immediately, and outputs take their reset values asynchronously.
- in_data, in_inv and in_tag are don't-care when in_valid=0. The unit still registers zero-valued fields deterministically; it never captures X into the MAIN register when accept=0.

## Structure
- Shared package aes_pkg holds:
  - the function computing offset s_r from (NB, r)
  - the generic permute function (data, inv, NB)
  - the enum typedef for mode (FWD, INV)
- Sub-module pipe_skid (parameter DW): a generic two-entry valid/ready skid buffer, instantiated with DW = W+TAG_W. The top level holds the permute and width checks.

## Test plan
- NB=4, forward, in_data=d42711ae_e0bf98f1_b8b45de5_1e415230 (FIPS-197 Appendix B, round 1) -> out_data=d4bf5d30_e0b452ae_b84111f1_1e2798e5 one cycle later.
- NB=4, inverse of that output -> original d42711ae… returned. Back-to-back alternating in_inv with out_ready=1 -> 1 beat/cycle with correct per-beat mode.
- NB=8, forward, byte k=4c+r holds value k (00..1f) -> out bytes (0,0)=00, (1,0)=05, (2,0)=0e, (3,0)=13. Inverse then restores the input exactly.
- Backpressure: out_ready=0 for 3 cycles while in_valid=1 with tags 1,2,3 -> in_ready falls after 2 accepts. out_data is stable throughout. Releasing out_ready delivers tags 1,2,3 in order with no gaps.
- flush in FULL state concurrent with in_valid=1 -> next cycle out_valid=0 and in_ready=1. Subsequent output contains only beats accepted after the flush.
- rst_n pulsed low for half a cycle during streaming -> out_valid=0 and out_data=0 asynchronously, in_ready=1. Streaming resumes correctly after release.
